// File: rtl/seg_scan_pkg.sv
// Shared types, constants and the digit-selection helper for the 8-digit
// seven-segment scan controller.
package seg_scan_pkg;

   localparam int NDIG  = 8;
   localparam int IDX_W = $clog2(NDIG);

   localparam logic [NDIG-1:0] ANODE_OFF = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      ADV  = 2'd2
   } state_t;

   // Lowest enabled digit strictly above cur, else the lowest enabled digit.
   function automatic logic [IDX_W-1:0] next_enabled(input logic [NDIG-1:0]  mask,
                                                     input logic [IDX_W-1:0] cur);
      logic [IDX_W-1:0] hi_idx;
      logic [IDX_W-1:0] lo_idx;
      logic             hi_ok;
      hi_idx = '0;
      lo_idx = '0;
      hi_ok  = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lo_idx = IDX_W'(i);
            if (i > int'(cur)) begin
               hi_idx = IDX_W'(i);
               hi_ok  = 1'b1;
            end
         end
      end
      return hi_ok ? hi_idx : lo_idx;
   endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Programmable tick prescaler: holds the divider and emits one tick every
// div cycles; a divider value of 0 is stored as 1.
module seg_scan_prescaler #(
   parameter int          DIV_W       = 16,
   parameter int unsigned DIV_DEFAULT = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_div_ld,
   input  logic [DIV_W-1:0] i_div_val,
   input  logic             i_restart,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_div_eff;

   assign w_div_eff = (i_div_val == '0) ? DIV_W'(1) : i_div_val;
   assign o_tick    = !i_restart && (r_cnt == (r_div - DIV_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= DIV_W'(DIV_DEFAULT);
         r_cnt <= '0;
      end else begin
         if (i_div_ld) begin
            r_div <= w_div_eff;
         end
         if (i_restart || o_tick) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with shadowed digit
// registers, per-digit enable and brightness duty. Build option:
// SEG_SCAN_DEADTIME_EN forces phase 15 of every slot blank.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int          DIV_W       = 16,
   parameter int unsigned DIV_DEFAULT = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [3:0]       wr_data,
   input  logic             div_ld,
   input  logic [DIV_W-1:0] div_val,
   input  logic [NDIG-1:0]  en_mask,
   input  logic [3:0]       bright,
   output logic [NDIG-1:0]  anode_n,
   output logic [3:0]       digit,
   output logic             frame_tick
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_cur;
   logic [IDX_W-1:0] w_cur_nxt;
   logic [IDX_W-1:0] w_adv_idx;
   logic [3:0]       r_phase;
   logic [3:0]       w_phase_nxt;
   logic             w_fstart;
   logic             r_first;
   logic             w_tick;
   logic             w_restart;
   logic             w_lit;

   logic [3:0]       r_shadow [NDIG];
   logic [3:0]       r_active [NDIG];
   logic [NDIG-1:0]  r_anode_n;
   logic [3:0]       r_digit;
   logic             r_frame_tick;

   // The prescaler only runs while scanning; ADV adds exactly one cycle per slot.
   assign w_restart = (r_state != SCAN) || div_ld;

   seg_scan_prescaler #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_div_ld  (div_ld),
      .i_div_val (div_val),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   assign w_adv_idx = next_enabled(en_mask, r_cur);

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_phase_nxt = r_phase;
      w_fstart    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cur_nxt   = '0;
            w_phase_nxt = '0;
            if (en_mask != '0) begin
               w_state_nxt = SCAN;
               w_cur_nxt   = next_enabled(en_mask, IDX_W'(NDIG - 1));
               w_fstart    = 1'b1;
            end
         end
         SCAN: begin
            if (en_mask == '0) begin
               w_state_nxt = IDLE;
               w_cur_nxt   = '0;
               w_phase_nxt = '0;
            end else if (div_ld) begin
               w_phase_nxt = '0;
            end else if (w_tick) begin
               w_phase_nxt = r_phase + 4'd1;
               if (r_phase == 4'd15) begin
                  w_state_nxt = ADV;
               end
            end
         end
         ADV: begin
            w_phase_nxt = '0;
            if (en_mask == '0) begin
               w_state_nxt = IDLE;
               w_cur_nxt   = '0;
            end else begin
               w_state_nxt = SCAN;
               w_cur_nxt   = w_adv_idx;
               // Wrapping to the same or a lower digit begins a new frame.
               w_fstart    = (w_adv_idx <= r_cur);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cur_nxt   = '0;
            w_phase_nxt = '0;
         end
      endcase
   end

`ifdef SEG_SCAN_DEADTIME_EN
   assign w_lit = (r_state == SCAN) && en_mask[r_cur] && (r_phase <= bright) &&
                  (r_phase != 4'd15);
`else
   assign w_lit = (r_state == SCAN) && en_mask[r_cur] && (r_phase <= bright);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cur   <= '0;
         r_phase <= '0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         r_phase <= w_phase_nxt;
         r_first <= w_fstart;
      end
   end

   // Copy reads the pre-write shadow, so a coincident write lands next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NDIG; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            r_shadow[wr_addr] <= wr_data;
         end
         if (w_fstart) begin
            for (int i = 0; i < NDIG; i++) begin
               r_active[i] <= r_shadow[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_anode_n    <= ANODE_OFF;
         r_digit      <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_anode_n    <= w_lit ? ~(NDIG'(1) << r_cur) : ANODE_OFF;
         r_digit      <= r_active[r_cur];
         r_frame_tick <= r_first;
      end
   end

   assign anode_n    = r_anode_n;
   assign digit      = r_digit;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: scan order, slot/frame timing, duty,
// tear-free digit update, enable changes and reset behaviour.
module tb_seg_scan_ctrl;

   localparam int DIV_W = 16;

`ifdef SEG_SCAN_DEADTIME_EN
   localparam int LIT_FULL_D2 = 30;
   localparam int GAP_FULL_D2 = 3;
   localparam int LIT_FULL_D1 = 15;
   localparam int GAP_FULL_D1 = 2;
   localparam int LIT_FULL_D4 = 60;
   localparam int GAP_FULL_D4 = 5;
`else
   localparam int LIT_FULL_D2 = 32;
   localparam int GAP_FULL_D2 = 1;
   localparam int LIT_FULL_D1 = 16;
   localparam int GAP_FULL_D1 = 1;
   localparam int LIT_FULL_D4 = 64;
   localparam int GAP_FULL_D4 = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_en;
   logic [2:0]       wr_addr;
   logic [3:0]       wr_data;
   logic             div_ld;
   logic [DIV_W-1:0] div_val;
   logic [7:0]       en_mask;
   logic [3:0]       bright;
   logic [7:0]       anode_n;
   logic [3:0]       digit;
   logic             frame_tick;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   seg_scan_ctrl #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (50000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .div_ld     (div_ld),
      .div_val    (div_val),
      .en_mask    (en_mask),
      .bright     (bright),
      .anode_n    (anode_n),
      .digit      (digit),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic run_len(input logic [7:0] pat, output int n);
      n = 0;
      while (anode_n == pat && n < 5000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_pat(input string tag, input logic [7:0] pat);
      int n;
      n = 0;
      while (anode_n != pat && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check(tag, int'(anode_n), int'(pat));
   endtask

   task automatic wait_ft(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!frame_tick && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check(tag, int'(frame_tick), 1);
   endtask

   task automatic do_write(input logic [2:0] a, input logic [3:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic load_div(input logic [DIV_W-1:0] v);
      div_ld  = 1'b1;
      div_val = v;
      @(negedge clk);
      div_ld  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t0;
      logic [7:0] pat;

      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      div_ld  = 1'b0;
      div_val = '0;
      en_mask = 8'h00;
      bright  = 4'd15;
      repeat (3) @(negedge clk);
      check("rst_anode", int'(anode_n), 'hFF);
      check("rst_digit", int'(digit), 0);
      check("rst_ft", int'(frame_tick), 0);

      rst_n = 1'b1;
      @(negedge clk);
      load_div(16'd4);
      for (int i = 0; i < 8; i++) do_write(3'(i), 4'(i));
      check("idle_anode", int'(anode_n), 'hFF);

      // Full 8-digit scan, div=4, full brightness
      en_mask = 8'hFF;
      @(negedge clk);
      check("start_lat_anode", int'(anode_n), 'hFF);
      check("start_lat_ft", int'(frame_tick), 0);
      @(negedge clk);
      check("start_anode", int'(anode_n), 'hFE);
      t0 = cyc;
      for (int k = 0; k < 8; k++) begin
         pat = ~(8'h01 << k);
         check($sformatf("d%0d_ft", k), int'(frame_tick), (k == 0) ? 1 : 0);
         check($sformatf("d%0d_val", k), int'(digit), k);
         run_len(pat, n);
         check($sformatf("d%0d_lit", k), n, LIT_FULL_D4);
         run_len(8'hFF, n);
         check($sformatf("d%0d_gap", k), n, GAP_FULL_D4);
      end
      check("frame2_anode", int'(anode_n), 'hFE);
      check("frame2_ft", int'(frame_tick), 1);
      check("frame_len", cyc - t0, 520);

      // Sparse mask: digits 0 and 2 only
      en_mask = 8'h05;
      t0 = cyc;
      run_len(8'hFE, n);
      check("m05_lit0", n, LIT_FULL_D4);
      run_len(8'hFF, n);
      check("m05_gap0", n, GAP_FULL_D4);
      check("m05_anode2", int'(anode_n), 'hFB);
      check("m05_digit2", int'(digit), 2);
      check("m05_ft2", int'(frame_tick), 0);
      run_len(8'hFB, n);
      check("m05_lit2", n, LIT_FULL_D4);
      run_len(8'hFF, n);
      check("m05_wrap_anode", int'(anode_n), 'hFE);
      check("m05_wrap_ft", int'(frame_tick), 1);
      check("m05_wrap_digit", int'(digit), 0);
      check("m05_frame_len", cyc - t0, 130);

      // Duty: bright=3, div=2
      bright = 4'd3;
      load_div(16'd2);
      wait_ft("b3_ft");
      run_len(8'hFE, n);
      check("b3_lit0", n, 8);
      run_len(8'hFF, n);
      check("b3_off0", n, 25);
      check("b3_anode2", int'(anode_n), 'hFB);
      run_len(8'hFB, n);
      check("b3_lit2", n, 8);
      run_len(8'hFF, n);
      check("b3_off2", n, 25);
      check("b3_wrap_ft", int'(frame_tick), 1);

      bright = 4'd15;
      wait_ft("b15_ft");
      run_len(8'hFE, n);
      check("b15_lit", n, LIT_FULL_D2);
      run_len(8'hFF, n);
      check("b15_off", n, GAP_FULL_D2);
      check("b15_anode2", int'(anode_n), 'hFB);

      // Tear-free digit update
      en_mask = 8'hFF;
      wait_ft("wr_ft_a");
      do_write(3'd3, 4'd9);
      wait_pat("wr_f7_a", 8'hF7);
      check("wr_old", int'(digit), 3);
      wait_ft("wr_ft_b");
      wait_pat("wr_f7_b", 8'hF7);
      check("wr_new", int'(digit), 9);
      wait_pat("wr_7f_b", 8'h7F);
      repeat (31) @(negedge clk);
      do_write(3'd3, 4'd6);
      @(negedge clk);
      check("wr_edge_ft", int'(frame_tick), 1);
      check("wr_edge_anode", int'(anode_n), 'hFE);
      wait_pat("wr_f7_c", 8'hF7);
      check("wr_coinc_excluded", int'(digit), 9);
      wait_ft("wr_ft_d");
      wait_pat("wr_f7_d", 8'hF7);
      check("wr_coinc_next", int'(digit), 6);

      // Enable mask drop and restore
      repeat (5) @(negedge clk);
      en_mask = 8'h00;
      @(negedge clk);
      check("drop_anode", int'(anode_n), 'hFF);
      check("drop_ft", int'(frame_tick), 0);
      repeat (4) @(negedge clk);
      check("drop_hold", int'(anode_n), 'hFF);
      en_mask = 8'hFF;
      @(negedge clk);
      check("restore_lat", int'(anode_n), 'hFF);
      @(negedge clk);
      check("restore_anode", int'(anode_n), 'hFE);
      check("restore_ft", int'(frame_tick), 1);
      t0 = cyc;
      repeat (10) @(negedge clk);
      en_mask = 8'hFE;
      @(negedge clk);
      check("clr_cur_anode", int'(anode_n), 'hFF);
      wait_pat("clr_cur_next", 8'hFD);
      check("clr_cur_slot", cyc - t0, 33);
      check("clr_cur_ft", int'(frame_tick), 0);

      // Divider 0 behaves as 1, then reset restores the default divider
      en_mask = 8'hFF;
      load_div(16'd0);
      wait_ft("d0_ft");
      run_len(8'hFE, n);
      check("d0_lit", n, LIT_FULL_D1);
      run_len(8'hFF, n);
      check("d0_gap", n, GAP_FULL_D1);
      check("d0_anode1", int'(anode_n), 'hFD);
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b0;
      bright = 4'd0;
      #1;
      check("arst_anode", int'(anode_n), 'hFF);
      check("arst_digit", int'(digit), 0);
      check("arst_ft", int'(frame_tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_lat", int'(anode_n), 'hFF);
      @(negedge clk);
      check("post_rst_anode", int'(anode_n), 'hFE);
      check("post_rst_ft", int'(frame_tick), 1);
      repeat (40) @(negedge clk);
      check("post_rst_div_default", int'(anode_n), 'hFE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
